pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage: holds the fetch PC, applies redirects from execute (jalr, branch mispredict) and decode (jal, taken branch prediction, predicted return), and advances by 2 or 4 bytes for compressed or full-length instructions. Adds an internal circular return address stack (RAS) so that decode-stage returns redirect without waiting for jalr resolution. Sits between the redirect sources and the instruction-cache request port.

## Interface
- `XLEN`, 64: PC and address width.
- `RESET_VEC`, 64'h80000000: PC value after reset, truncated to `XLEN`.
- `BR_OFFS_W`, 13: width of the predicted-branch offset, sign-extended to `XLEN`.
- `RAS_DEPTH`, 8: RAS entries; power of two, at least 2.

- `clk`  in  1  clock, rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold PC and RAS.
- `jalr_taken`  in  1  execute-stage jalr redirect.
- `jalr_addr`  in  XLEN  jalr target.
- `pr_miss`  in  1  execute-stage branch mispredict.
- `br_addr`  in  XLEN  corrected branch target.
- `ras_pop`  in  1  decode: instruction is a return (predict from RAS).
- `ras_push`  in  1  decode: instruction is a call (push link address).
- `ras_push_addr`  in  XLEN  link address to push.
- `jal_taken`  in  1  decode-stage jal redirect.
- `jal_addr`  in  XLEN  jal target.
- `pr_taken`  in  1  decode: branch predicted taken.
- `pr_offs`  in  BR_OFFS_W  predicted-branch byte offset, signed.
- `rvc`  in  1  current instruction is compressed; sequential step is 2, else 4.
- `pc`  out  XLEN  current fetch PC.
- `ras_empty`  out  1  RAS holds no entries.
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries.

## Operation
- Reset (`clr`=1 at an edge): `pc`=`RESET_VEC`, RAS count=0, top pointer=0, all entries=0; `ras_empty`=1, `ras_full`=0. Reset overrides `stall` and all redirects.
- `stall`=1: `pc`, RAS storage, pointer and count all hold; every other input is ignored.
- Next-PC priority, highest first: `jalr_taken` -> `jalr_addr`; `pr_miss` -> `br_addr`; `ras_pop` with RAS non-empty -> current RAS top; `jal_taken` -> `jal_addr`; `pr_taken` -> `pc` + sext(`pr_offs`); otherwise `pc` + (`rvc` ? 2 : 4).
- `ras_pop` with RAS empty: no PC effect; selection falls through to lower priorities. Count stays 0.
- Execute redirect (`jalr_taken` or `pr_miss`) squashes the same cycle's `ras_push`/`ras_pop`, since those come from a wrong-path instruction. The RAS is not restored.
- Push only: pointer advances mod `RAS_DEPTH` and `ras_push_addr` is written at the new top. Count increments and saturates at `RAS_DEPTH`. When full, the push overwrites the oldest entry (wrap-around).
- Pop only on non-empty: pointer retreats mod `RAS_DEPTH` and count decrements.
- Push and pop together on non-empty (coroutine swap): `pc` takes the old top, `ras_push_addr` is written in place at the top, and pointer and count are unchanged. On empty: treated as push only.
- All additions are modulo 2^`XLEN`; PC wrap-around is not flagged.

## Timing
- Single cycle: inputs are sampled at the rising edge and `pc` takes the new value at that edge. There is no combinational path from inputs to `pc`.
- The RAS top feeding the next-PC mux is read from registered storage, so it reflects pushes from earlier cycles only. A push at edge N is poppable at edge N+1.
- `ras_empty` and `ras_full` are decoded from the registered count and change the cycle after the push or pop.
- Deasserting `clr` causes the first fetch from `RESET_VEC` in that cycle; the following edge advances normally.

## Structure
- Package `pc_pkg`: default `RESET_VEC`, instruction step constants (2, 4), and an enumerated next-PC select (`NPC_JALR`, `NPC_BR`, `NPC_RAS`, `NPC_JAL`, `NPC_PRED`, `NPC_SEQ`).
- Sub-module `ras`: storage array, top pointer, saturating count, and push/pop/swap logic, with inputs `push`, `pop`, `din`, `en` and outputs `top`, `empty`, `full`.
- `pc_gen` contains the priority select, squash logic and the PC register.

## Test plan
- Reset, then 3 idle cycles with `rvc`=0,1,0: `pc`=80000000, 80000004, 80000006, 8000000A.
- `pr_taken` with `pr_offs`=13'h1FF8 (−8) at `pc`=80000010: next `pc`=80000008. Then `jal_taken` with `pr_taken` both set: `jal_addr` wins.
- Push A0, B0, then pop twice, then pop on empty: `pc`=B0, then A0, then sequential step. `ras_empty` rises after the second pop.
- With `RAS_DEPTH`=8, 9 pushes (values 1..9) then 8 pops: `pc` sequence 9, 8, …, 2, and `ras_full`=1 after the 8th push.
- `jalr_taken`, `pr_miss` and `ras_pop` together: `pc`=`jalr_addr` and RAS count unchanged. `stall` together with every redirect: `pc` holds.
- Swap with top=C0 and push addr D0: `pc`=C0, count unchanged, next pop returns D0. Then `clr` mid-sequence: `pc`=80000000 and `ras_empty`=1.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_pkg                                                           |
// | Shared constants and next-PC select encoding for pc_gen.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pc_pkg;

    localparam logic [63:0] RESET_VEC_DEFAULT = 64'h8000_0000;
    localparam int unsigned STEP_RVC          = 2;
    localparam int unsigned STEP_FULL         = 4;

    typedef enum logic [2:0] {
        NPC_JALR = 3'd0,
        NPC_BR   = 3'd1,
        NPC_RAS  = 3'd2,
        NPC_JAL  = 3'd3,
        NPC_PRED = 3'd4,
        NPC_SEQ  = 3'd5
    } npc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_gen_ras.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ras                                                              |
// | Circular return address stack with saturating count and swap.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ras #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int              c_PW    = $clog2(DEPTH);
    localparam int              c_CW    = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] w_ptr_inc;
    logic [c_PW-1:0] w_ptr_dec;
    logic            w_pop_ok;

    assign w_ptr_inc = r_ptr + c_PW'(1);
    assign w_ptr_dec = r_ptr - c_PW'(1);
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_DEPTH);
    assign top       = r_mem[r_ptr];
    assign w_pop_ok  = pop && !empty;

    // A push onto a full stack wraps and silently overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (en) begin
            if (push && w_pop_ok) begin
                r_mem[r_ptr] <= din;
            end else if (push) begin
                r_ptr            <= w_ptr_inc;
                r_mem[w_ptr_inc] <= din;
                if (!full) begin
                    r_count <= r_count + c_CW'(1);
                end
            end else if (w_pop_ok) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - c_CW'(1);
            end
        end
    end

endmodule : ras
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_gen                                                           |
// | Fetch PC register with prioritised redirects and a return stack. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pc_gen
    import pc_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int          BR_OFFS_W = 13,
    parameter int          RAS_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 stall,
    input  logic                 jalr_taken,
    input  logic [XLEN-1:0]      jalr_addr,
    input  logic                 pr_miss,
    input  logic [XLEN-1:0]      br_addr,
    input  logic                 ras_pop,
    input  logic                 ras_push,
    input  logic [XLEN-1:0]      ras_push_addr,
    input  logic                 jal_taken,
    input  logic [XLEN-1:0]      jal_addr,
    input  logic                 pr_taken,
    input  logic [BR_OFFS_W-1:0] pr_offs,
    input  logic                 rvc,
    output logic [XLEN-1:0]      pc,
    output logic                 ras_empty,
    output logic                 ras_full
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_npc;
    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_offs;
    logic [XLEN-1:0] w_ras_top;
    logic            w_exec_redir;
    logic            w_ras_en;
    npc_sel_e        w_sel;

    // Execute redirects mean decode holds a wrong-path instruction; its RAS op is dropped.
    assign w_exec_redir = jalr_taken || pr_miss;
    assign w_ras_en     = !stall && !w_exec_redir;

    assign w_step = rvc ? XLEN'(STEP_RVC) : XLEN'(STEP_FULL);
    assign w_offs = {{(XLEN-BR_OFFS_W){pr_offs[BR_OFFS_W-1]}}, pr_offs};

    ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .clr   (clr),
        .en    (w_ras_en),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (ras_push_addr),
        .top   (w_ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_comb begin
        w_sel = NPC_SEQ;
        if (jalr_taken)                   w_sel = NPC_JALR;
        else if (pr_miss)                 w_sel = NPC_BR;
        else if (ras_pop && !ras_empty)   w_sel = NPC_RAS;
        else if (jal_taken)               w_sel = NPC_JAL;
        else if (pr_taken)                w_sel = NPC_PRED;
    end

    always_comb begin
        w_npc = r_pc + w_step;
        case (w_sel)
            NPC_JALR: w_npc = jalr_addr;
            NPC_BR:   w_npc = br_addr;
            NPC_RAS:  w_npc = w_ras_top;
            NPC_JAL:  w_npc = jal_addr;
            NPC_PRED: w_npc = r_pc + w_offs;
            default:  w_npc = r_pc + w_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc <= XLEN'(RESET_VEC);
        end else if (!stall) begin
            r_pc <= w_npc;
        end
    end

    assign pc = r_pc;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_gen                                                        |
// | Directed vector bench for pc_gen with return-stack sequences.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pc_gen;

    logic        clk;
    logic        clr;
    logic        stall;
    logic        jalr_taken;
    logic [63:0] jalr_addr;
    logic        pr_miss;
    logic [63:0] br_addr;
    logic        ras_pop;
    logic        ras_push;
    logic [63:0] ras_push_addr;
    logic        jal_taken;
    logic [63:0] jal_addr;
    logic        pr_taken;
    logic [12:0] pr_offs;
    logic        rvc;
    logic [63:0] pc;
    logic        ras_empty;
    logic        ras_full;

    int n_checks;
    int n_fail;

    typedef struct {
        string       name;
        logic        clr;
        logic        stall;
        logic        jalr;
        logic [63:0] jalr_a;
        logic        miss;
        logic [63:0] br_a;
        logic        pop;
        logic        push;
        logic [63:0] push_a;
        logic        jal;
        logic [63:0] jal_a;
        logic        prt;
        logic [12:0] offs;
        logic        rvc;
        logic [63:0] e_pc;
        logic        e_empty;
        logic        e_full;
    } vec_t;

    localparam int c_NVEC = 32;
    vec_t r_tbl [c_NVEC];

    pc_gen u_dut (
        .clk           (clk),
        .clr           (clr),
        .stall         (stall),
        .jalr_taken    (jalr_taken),
        .jalr_addr     (jalr_addr),
        .pr_miss       (pr_miss),
        .br_addr       (br_addr),
        .ras_pop       (ras_pop),
        .ras_push      (ras_push),
        .ras_push_addr (ras_push_addr),
        .jal_taken     (jal_taken),
        .jal_addr      (jal_addr),
        .pr_taken      (pr_taken),
        .pr_offs       (pr_offs),
        .rvc           (rvc),
        .pc            (pc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pc(input string name, input logic [63:0] exp);
        n_checks++;
        if (pc !== exp) begin
            n_fail++;
            $display("FAIL %s.pc: got %h expected %h", name, pc, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, let the rising edge take it, check 1ns later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        clr           = v.clr;
        stall         = v.stall;
        jalr_taken    = v.jalr;
        jalr_addr     = v.jalr_a;
        pr_miss       = v.miss;
        br_addr       = v.br_a;
        ras_pop       = v.pop;
        ras_push      = v.push;
        ras_push_addr = v.push_a;
        jal_taken     = v.jal;
        jal_addr      = v.jal_a;
        pr_taken      = v.prt;
        pr_offs       = v.offs;
        rvc           = v.rvc;
        @(posedge clk);
        #1;
        check_pc(v.name, v.e_pc);
        check_bit({v.name, ".empty"}, ras_empty, v.e_empty);
        check_bit({v.name, ".full"}, ras_full, v.e_full);
    endtask

    function automatic vec_t quiet(input string name, input logic [63:0] e_pc,
                                   input logic e_empty, input logic e_full);
        vec_t v;
        v = '{name, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
              1'b0, 64'h0, 1'b0, 13'h0, 1'b0, e_pc, e_empty, e_full};
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [63:0] exp_pc;
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1; stall = 1'b0; jalr_taken = 1'b0; jalr_addr = '0; pr_miss = 1'b0;
        br_addr = '0; ras_pop = 1'b0; ras_push = 1'b0; ras_push_addr = '0;
        jal_taken = 1'b0; jal_addr = '0; pr_taken = 1'b0; pr_offs = '0; rvc = 1'b0;

        //                name             clr  stl  jalr jalr_a  miss br_a    pop  push push_a  jal  jal_a  prt  offs      rvc  e_pc    emp  full
        r_tbl[0]  = '{"reset",          1, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'h8000_0000, 1, 0};
        r_tbl[1]  = '{"seq4",           0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'h8000_0004, 1, 0};
        r_tbl[2]  = '{"seq2",           0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   0, 13'h0,    1, 64'h8000_0006, 1, 0};
        r_tbl[3]  = '{"seq4b",          0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'h8000_000A, 1, 0};
        r_tbl[4]  = '{"jal",            0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  1, 64'h8000_0010, 0, 13'h0, 0, 64'h8000_0010, 1, 0};
        r_tbl[5]  = '{"pred_neg",       0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   1, 13'h1FF8, 0, 64'h8000_0008, 1, 0};
        r_tbl[6]  = '{"jal_over_pred",  0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  1, 64'h100, 1, 13'h0040, 0, 64'h100,  1, 0};
        r_tbl[7]  = '{"pred_pos_max",   0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   1, 13'h0FFE, 1, 64'h10FE, 1, 0};
        r_tbl[8]  = '{"push_a0",        0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'hA0, 0, 64'h0,   0, 13'h0,    0, 64'h1102, 0, 0};
        r_tbl[9]  = '{"push_b0",        0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'hB0, 0, 64'h0,   0, 13'h0,    0, 64'h1106, 0, 0};
        r_tbl[10] = '{"pop_b0",         0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'hB0,   0, 0};
        r_tbl[11] = '{"pop_a0",         0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'hA0,   1, 0};
        r_tbl[12] = '{"pop_empty",      0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    1, 64'hA2,   1, 0};
        r_tbl[13] = '{"push_e0",        0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'hE0, 0, 64'h0,   0, 13'h0,    0, 64'hA6,   0, 0};
        r_tbl[14] = '{"jalr_miss_pop",  0, 0, 1, 64'h200, 1, 64'h300, 1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'h200,  0, 0};
        r_tbl[15] = '{"pop_e0",         0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'hE0,   1, 0};
        r_tbl[16] = '{"jalr_sq_push",   0, 0, 1, 64'h280, 0, 64'h0,   0, 1, 64'hF0, 0, 64'h0,   0, 13'h0,    0, 64'h280,  1, 0};
        r_tbl[17] = '{"pop_empty_jal",  0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  1, 64'h500, 0, 13'h0,    0, 64'h500,  1, 0};
        r_tbl[18] = '{"miss_over_jal",  0, 0, 0, 64'h0,   1, 64'h400, 0, 0, 64'h0,  1, 64'h600, 1, 13'h0010, 0, 64'h400,  1, 0};
        r_tbl[19] = '{"push_c0",        0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'hC0, 0, 64'h0,   0, 13'h0,    0, 64'h404,  0, 0};
        r_tbl[20] = '{"stall_all",      0, 1, 1, 64'h900, 1, 64'h910, 1, 1, 64'h77, 1, 64'h920, 1, 13'h0010, 1, 64'h404,  0, 0};
        r_tbl[21] = '{"swap_c0",        0, 0, 0, 64'h0,   0, 64'h0,   1, 1, 64'hD0, 0, 64'h0,   0, 13'h0,    0, 64'hC0,   0, 0};
        r_tbl[22] = '{"pop_d0",         0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'hD0,   1, 0};
        r_tbl[23] = '{"push_11",        0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h11, 0, 64'h0,   0, 13'h0,    0, 64'hD4,   0, 0};
        r_tbl[24] = '{"clr_mid",        1, 1, 1, 64'h900, 0, 64'h0,   1, 1, 64'h55, 0, 64'h0,   0, 13'h0,    0, 64'h8000_0000, 1, 0};
        r_tbl[25] = '{"after_clr",      0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   0, 13'h0,    1, 64'h8000_0002, 1, 0};
        r_tbl[26] = '{"jal_top",        0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 13'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0};
        r_tbl[27] = '{"pc_wrap",        0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'h0,    1, 0};
        r_tbl[28] = '{"swap_on_empty",  0, 0, 0, 64'h0,   0, 64'h0,   1, 1, 64'h33, 0, 64'h0,   0, 13'h0,    0, 64'h4,    0, 0};
        r_tbl[29] = '{"pop_33",         0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  0, 64'h0,   0, 13'h0,    0, 64'h33,   1, 0};
        r_tbl[30] = '{"push_44",        0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h44, 0, 64'h0,   0, 13'h0,    0, 64'h37,   0, 0};
        r_tbl[31] = '{"pop_over_jal",   0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h0,  1, 64'h999, 0, 13'h0,    0, 64'h44,   1, 0};

        for (int i = 0; i < c_NVEC; i++) begin
            apply(r_tbl[i]);
        end

        // Nine pushes of 1..9 into an 8-deep stack: the 9th overwrites value 1.
        exp_pc = 64'h44;
        for (int i = 1; i <= 9; i++) begin
            exp_pc = exp_pc + 64'd4;
            v = quiet($sformatf("fill_%0d", i), exp_pc, 1'b0, (i >= 8));
            v.push   = 1'b1;
            v.push_a = 64'(i);
            apply(v);
        end
        for (int i = 0; i < 8; i++) begin
            v = quiet($sformatf("drain_%0d", i), 64'(9 - i), (i == 7), 1'b0);
            v.pop = 1'b1;
            apply(v);
        end

        // Stall holds PC over several cycles, then the held PC advances.
        exp_pc = 64'h2;
        for (int i = 0; i < 2; i++) begin
            v = quiet($sformatf("hold_%0d", i), exp_pc, 1'b1, 1'b0);
            v.stall = 1'b1;
            v.jal   = 1'b1;
            v.jal_a = 64'h1234;
            apply(v);
        end
        apply(quiet("release", 64'h6, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
